// File: rtl/dtfag_pkg.sv
// dtfag_pkg: shared sizes, field bit ranges, exponent/group types and FSM states for the DTFAG ROM address generator
package dtfag_pkg;
  localparam int N_LOG2 = 16;
  localparam int RADIX_LOG2 = 4;
  localparam int NBANK = 8;
  localparam int ADDR_W = 7;
  localparam int NK = 1 << RADIX_LOG2;
  localparam int F0_HI = 15;
  localparam int F0_LO = 10;
  localparam int F1_HI = 9;
  localparam int F1_LO = 5;
  localparam int F2_HI = 4;
  localparam int F2_LO = 0;
  typedef logic [N_LOG2-1:0] exp_t;
  typedef logic [N_LOG2-RADIX_LOG2-1:0] grp_t;
  typedef enum logic [1:0] {IDLE, RUN_P0, RUN_P1, DONE} state_t;
endpackage

// File: rtl/dtfag_rom_addr_gen_if.sv
// dtfag_rom_addr_gen_if: control handshake, 3x8 ROM bank request bus and Q-side tag stream; master = controller/bench, slave = generator
interface dtfag_rom_addr_gen_if;
  import dtfag_pkg::*;
  logic start;
  logic [1:0] stage;
  logic hold;
  logic busy;
  logic done;
  logic [NBANK-1:0] rom0_cen;
  logic [NBANK-1:0] rom1_cen;
  logic [NBANK-1:0] rom2_cen;
  logic [NBANK*ADDR_W-1:0] rom0_a;
  logic [NBANK*ADDR_W-1:0] rom1_a;
  logic [NBANK*ADDR_W-1:0] rom2_a;
  logic [NBANK-1:0] rom_unity;
  logic q_valid;
  logic q_phase;
  grp_t q_group;
  modport master (
    output start, stage, hold,
    input busy, done, rom0_cen, rom1_cen, rom2_cen, rom0_a, rom1_a, rom2_a,
    input rom_unity, q_valid, q_phase, q_group
  );
  modport slave (
    input start, stage, hold,
    output busy, done, rom0_cen, rom1_cen, rom2_cen, rom0_a, rom1_a, rom2_a,
    output rom_unity, q_valid, q_phase, q_group
  );
endinterface

// File: rtl/dtfag_exp_split.sv
// dtfag_exp_split: splits exponent e into zero-extended ROM0/ROM1/ROM2 field addresses a0/a1/a2 plus zero flag (e == 0)
module dtfag_exp_split
  import dtfag_pkg::*;
(
  input  exp_t              e,
  output logic [ADDR_W-1:0] a0,
  output logic [ADDR_W-1:0] a1,
  output logic [ADDR_W-1:0] a2,
  output logic              zero
);
  assign a0 = ADDR_W'(e[F0_HI:F0_LO]);
  assign a1 = ADDR_W'(e[F1_HI:F1_LO]);
  assign a2 = ADDR_W'(e[F2_HI:F2_LO]);
  assign zero = e == '0;
endmodule

// File: rtl/dtfag_rom_addr_gen.sv
// dtfag_rom_addr_gen: per-stage twiddle exponent walker driving 3 ROMs x 8 banks; ports clk, rst (sync, active-high), bus (slave: start/stage/hold in; busy/done/CEN/A/unity/q_* out); optional DTFAG_UNITY_GATE_EN gates zero-field banks and flags unity
module dtfag_rom_addr_gen
  import dtfag_pkg::*;
(
  input logic clk,
  input logic rst,
  dtfag_rom_addr_gen_if.slave bus
);
`ifdef DTFAG_UNITY_GATE_EN
  localparam bit UNITY = 1'b1;
`else
  localparam bit UNITY = 1'b0;
`endif
  state_t state;
  logic [1:0] stage_r;
  exp_t acc [NK];
  grp_t j;
  logic req;
  logic phase_r;
  grp_t grp_r;
  logic [NBANK-1:0] unity_r;
  exp_t e [NBANK];
  logic [ADDR_W-1:0] a0 [NBANK];
  logic [ADDR_W-1:0] a1 [NBANK];
  logic [ADDR_W-1:0] a2 [NBANK];
  logic [NBANK-1:0] z;
  logic run;
  assign run = (state == RUN_P0 || state == RUN_P1) && !bus.hold;
  // bank b carries k=b in phase 0 and k=b+8 in phase 1
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign e[b] = state == RUN_P1 ? acc[b+NBANK] : acc[b];
    dtfag_exp_split u_split (.e(e[b]), .a0(a0[b]), .a1(a1[b]), .a2(a2[b]), .zero(z[b]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stage_r <= '0;
      j <= '0;
      for (int k = 0; k < NK; k++) acc[k] <= '0;
      bus.rom0_cen <= '1;
      bus.rom1_cen <= '1;
      bus.rom2_cen <= '1;
      bus.rom0_a <= '0;
      bus.rom1_a <= '0;
      bus.rom2_a <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q_valid <= 1'b0;
      bus.q_phase <= 1'b0;
      bus.q_group <= '0;
      bus.rom_unity <= '0;
      req <= 1'b0;
      phase_r <= 1'b0;
      grp_r <= '0;
      unity_r <= '0;
    end else begin
      // request tags are delayed one cycle to line up with ROM Q
      req <= run;
      phase_r <= state == RUN_P1;
      grp_r <= j;
      unity_r <= UNITY ? z : '0;
      bus.q_valid <= req;
      bus.q_phase <= phase_r;
      bus.q_group <= grp_r;
      bus.rom_unity <= req ? unity_r : '0;
      bus.done <= 1'b0;
      // a held or idle cycle disables every bank but leaves addresses where they were
      for (int b = 0; b < NBANK; b++) begin
        bus.rom0_cen[b] <= !run || (UNITY && a0[b] == '0);
        bus.rom1_cen[b] <= !run || (UNITY && a1[b] == '0);
        bus.rom2_cen[b] <= !run || (UNITY && a2[b] == '0);
        if (run) begin
          bus.rom0_a[b*ADDR_W +: ADDR_W] <= a0[b];
          bus.rom1_a[b*ADDR_W +: ADDR_W] <= a1[b];
          bus.rom2_a[b*ADDR_W +: ADDR_W] <= a2[b];
        end
      end
      case (state)
        IDLE: if (bus.start) begin
          state <= RUN_P0;
          stage_r <= bus.stage;
          j <= '0;
          for (int k = 0; k < NK; k++) acc[k] <= '0;
          bus.busy <= 1'b1;
        end
        RUN_P0: if (!bus.hold) state <= RUN_P1;
        RUN_P1: if (!bus.hold) begin
          // step_k = k * 16^stage, a shift rather than a multiply
          for (int k = 0; k < NK; k++) acc[k] <= acc[k] + (exp_t'(k) << {stage_r, 2'b00});
          j <= j + grp_t'(1);
          state <= j == '1 ? DONE : RUN_P0;
          bus.done <= j == '1;
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dtfag_rom_addr_gen.sv
// tb_dtfag_rom_addr_gen: scoreboard bench; expected exponents computed as k*j*16^stage mod 2^16 and checked when q_valid appears
module tb_dtfag_rom_addr_gen;
  import dtfag_pkg::*;
`ifdef DTFAG_UNITY_GATE_EN
  localparam bit UG = 1'b1;
`else
  localparam bit UG = 1'b0;
`endif
  typedef struct {
    int grp;
    bit ph;
    logic [NBANK*ADDR_W-1:0] a0, a1, a2;
    logic [NBANK-1:0] c0, c1, c2, un;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  dtfag_rom_addr_gen_if bus ();
  dtfag_rom_addr_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  item_t sb [$];
  int compared = 0;
  int mismatched = 0;
  int qv_count = 0;
  int done_cnt = 0;
  bit skip = 1'b1;
  bit done_prev = 1'b0;
  logic [3*NBANK-1:0] prev_cen = '1;
  logic [NBANK*ADDR_W-1:0] prev_a0 = '0, prev_a1 = '0, prev_a2 = '0;
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", n, act, req, $time);
    end
  endtask
  task automatic push_model(input int s);
    for (int j = 0; j < 4096; j++)
      for (int p = 0; p < 2; p++) begin
        item_t it;
        it.grp = j;
        it.ph = p[0];
        for (int b = 0; b < NBANK; b++) begin
          int unsigned e, f0, f1, f2;
          e = ((b + 8 * p) * j * (1 << (4 * s))) % 65536;
          f0 = e / 1024;
          f1 = (e / 32) % 32;
          f2 = e % 32;
          it.a0[b*ADDR_W +: ADDR_W] = ADDR_W'(f0);
          it.a1[b*ADDR_W +: ADDR_W] = ADDR_W'(f1);
          it.a2[b*ADDR_W +: ADDR_W] = ADDR_W'(f2);
          it.c0[b] = UG && f0 == 0;
          it.c1[b] = UG && f1 == 0;
          it.c2[b] = UG && f2 == 0;
          it.un[b] = UG && e == 0;
        end
        sb.push_back(it);
      end
  endtask
  always @(negedge clk) begin
    if (skip) skip = 1'b0;
    else begin
      if (bus.q_valid) begin
        qv_count++;
        if (sb.size() == 0) check("unexpected_q_valid", 1, 0);
        else begin
          item_t it;
          it = sb.pop_front();
          check("q_group", 64'(bus.q_group), 64'(it.grp));
          check("q_phase", 64'(bus.q_phase), 64'(it.ph));
          check("rom0_a", 64'(prev_a0), 64'(it.a0));
          check("rom1_a", 64'(prev_a1), 64'(it.a1));
          check("rom2_a", 64'(prev_a2), 64'(it.a2));
          check("cen", 64'(prev_cen), 64'({it.c0, it.c1, it.c2}));
          check("rom_unity", 64'(bus.rom_unity), 64'(it.un));
        end
      end else check("cen_idle", 64'(prev_cen), 64'({3*NBANK{1'b1}}));
      if (done_prev) check("busy_after_done", 64'(bus.busy), 0);
      if (bus.done) begin
        done_cnt++;
        check("busy_with_done", 64'(bus.busy), 1);
      end
    end
    done_prev = bus.done;
    prev_cen = {bus.rom0_cen, bus.rom1_cen, bus.rom2_cen};
    prev_a0 = bus.rom0_a;
    prev_a1 = bus.rom1_a;
    prev_a2 = bus.rom2_a;
    if (rst) begin
      sb.delete();
      skip = 1'b1;
    end
  end
  task automatic check_reset();
    check("rst_cen", 64'({bus.rom0_cen, bus.rom1_cen, bus.rom2_cen}), 64'({3*NBANK{1'b1}}));
    check("rst_a0", 64'(bus.rom0_a), 0);
    check("rst_a12", 64'(bus.rom1_a | bus.rom2_a), 0);
    check("rst_flags", 64'({bus.busy, bus.done, bus.q_valid, bus.q_phase}), 0);
    check("rst_group", 64'(bus.q_group), 0);
    check("rst_unity", 64'(bus.rom_unity), 0);
  endtask
  task automatic run_stage(input int s, input bit rand_hold, input int hold_at, input int abort_at);
    push_model(s);
    done_cnt = 0;
    qv_count = 0;
    bus.start = 1'b1;
    bus.stage = 2'(s);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c < 20000; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        rst = 1'b1;
        bus.hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        return;
      end
      bus.start = c == 1000;
      bus.stage = c == 1000 ? 2'd3 : 2'($urandom);
      bus.hold = (hold_at > 0 && c >= hold_at && c < hold_at + 5) || (rand_hold && $urandom_range(0, 7) == 0);
      if (hold_at > 0 && c > hold_at && c <= hold_at + 6) begin
        @(negedge clk);
        if (c <= hold_at + 5) check("hold_cen", 64'({bus.rom0_cen, bus.rom1_cen, bus.rom2_cen}), 64'({3*NBANK{1'b1}}));
        if (c >= hold_at + 2) check("hold_q_valid", 64'(bus.q_valid), 0);
      end
      if (!bus.busy) break;
    end
    bus.hold = 1'b0;
    check("run_complete", 64'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("q_valid_count", 64'(qv_count), 8192);
    check("done_count", 64'(done_cnt), 1);
    check("sb_empty", 64'(sb.size()), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stage = 2'd0;
    bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    run_stage(0, 1'b0, 200, 0);
    run_stage(3, 1'b1, 0, 0);
    run_stage(2, 1'b0, 0, 4000);
    run_stage(1, 1'b0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end
endmodule
